// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: shifts {write, addr[6:0], data[7:0]} MSB-first on COPI, nCS low 33*CLK_DIV cycles.
// Valid/ready request side; define SPI_CTRL_FIFO_EN for a 4-deep request FIFO (otherwise ready only while idle).
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shreg;
  logic [15:0]      frame_in;
  logic [15:0]      start_word;
  logic             start;
  logic             fifo_busy;
  logic             div_last;
  logic             gap_last;
  logic             frame_active;

  assign frame_in = {req_write, req_addr, req_data};

`ifdef SPI_CTRL_FIFO_EN
  logic [15:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_cnt;
  logic [2:0]  fifo_cnt_nxt;
  logic        ready_q;
  logic        push;
  logic        pop;

  // A full FIFO refuses pushes even when the FSM pops in the same cycle.
  assign push         = req_valid && ready_q;
  assign pop          = (state == ST_IDLE) && (fifo_cnt != 3'd0);
  assign fifo_cnt_nxt = fifo_cnt + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= frame_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_cnt <= fifo_cnt_nxt;
      ready_q  <= (fifo_cnt_nxt != 3'd4);
    end
  end

  assign start      = pop;
  assign start_word = fifo_mem[rd_ptr];
  assign req_ready  = ready_q;
  assign fifo_busy  = (fifo_cnt != 3'd0);
`else
  assign start      = req_valid && (state == ST_IDLE);
  assign start_word = frame_in;
  assign req_ready  = (state == ST_IDLE);
  assign fifo_busy  = 1'b0;
`endif

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= 4'd0;
      shreg   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            shreg   <= start_word;
            div_cnt <= '0;
            bit_cnt <= 4'd0;
          end
        end
        ST_SETUP: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state <= ST_HI;
          end
        end
        ST_HI: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            if (bit_cnt == 4'd15) begin
              state <= ST_HOLD;
            end else begin
              // COPI moves to the next bit on the falling SCLK edge.
              state   <= ST_LO;
              shreg   <= {shreg[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_LO: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state <= ST_HI;
          end
        end
        ST_HOLD: begin
          div_cnt <= div_last ? '0 : div_cnt + 1'b1;
          if (div_last) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
          if (gap_last) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from async-reset state, so reset idles the pins immediately.
  assign frame_active = (state == ST_SETUP) || (state == ST_HI) ||
                        (state == ST_LO) || (state == ST_HOLD);
  assign nCS  = !frame_active;
  assign SCLK = (state == ST_HI);
  assign COPI = frame_active && shreg[15];
  assign done = (state == ST_GAP) && (gap_cnt == '0);
  assign busy = (state != ST_IDLE) || fifo_busy;

endmodule
